reg_file_param: RTL and testbench

Parametrised multi-port register file that generalises the single 32-bit load register: DEPTH words of WIDTH bits, one write port, two independent synchronous read ports, and an optional hardwired zero register. It adds a runtime bulk-clear sequencer that walks every entry to zero without asserting reset. It sits between the datapath's operand-fetch stage and the writeback stage.

---
 rtl/reg_file_param.sv | 122 ++++++++++++
 tb/tb_reg_file_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// reg_file_param: DEPTH x WIDTH register file with one write port, two registered read ports,
// an optional hardwired zero entry and a runtime bulk-clear sequencer. Macro: REGFILE_BYPASS_EN.
module reg_file_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_ra_en,
    input  logic [AW-1:0]    i_ra_addr,
    output logic [WIDTH-1:0] o_ra_data,
    input  logic             i_rb_en,
    input  logic [AW-1:0]    i_rb_addr,
    output logic [WIDTH-1:0] o_rb_data,
    input  logic             i_clr_req,
    output logic             o_busy
);
    // Handshake: i_clr_req is a one-cycle request honoured only in IDLE; o_busy is high
    // from the edge that accepts it until the edge that clears the last entry.
    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam bit            ZR       = (ZERO_REG != 0);

    state_t           r_state;
    state_t           w_next_state;
    logic [AW-1:0]    r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_ra_data;
    logic [WIDTH-1:0] r_rb_data;
    logic [WIDTH-1:0] w_ra_next;
    logic [WIDTH-1:0] w_rb_next;
    logic             w_wr_en;
    logic             w_clr_en;
    logic             w_waddr_ok;
    logic             w_ra_ok;
    logic             w_rb_ok;

    // Address 0 is neither writable nor readable when the zero register is enabled.
    assign w_waddr_ok = ({1'b0, i_waddr} < DEPTH_W) && !(ZR && (i_waddr == '0));
    assign w_ra_ok    = ({1'b0, i_ra_addr} < DEPTH_W) && !(ZR && (i_ra_addr == '0));
    assign w_rb_ok    = ({1'b0, i_rb_addr} < DEPTH_W) && !(ZR && (i_rb_addr == '0));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == S_CLEAR);
            if (w_clr_en)
                r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_clr_req) w_next_state = S_CLEAR;
            S_CLEAR: if (r_cnt == LAST_IDX) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_clr_en = (r_state == S_CLEAR);
        w_wr_en  = (r_state == S_IDLE) && !i_clr_req && i_we && w_waddr_ok;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_clr_en) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        w_ra_next = '0;
        w_rb_next = '0;
        if (w_ra_ok) begin
            w_ra_next = r_mem[i_ra_addr];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_en && (i_waddr == i_ra_addr))
                w_ra_next = i_wdata;
`endif
        end
        if (w_rb_ok) begin
            w_rb_next = r_mem[i_rb_addr];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_en && (i_waddr == i_rb_addr))
                w_rb_next = i_wdata;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ra_data <= '0;
            r_rb_data <= '0;
        end else begin
            if (i_ra_en) r_ra_data <= w_ra_next;
            if (i_rb_en) r_rb_data <= w_rb_next;
        end
    end

    assign o_ra_data = r_ra_data;
    assign o_rb_data = r_rb_data;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: directed plan plus random traffic against an array model,
// and a second DEPTH=20 instance for the non-power-of-two depth cases.
module tb_reg_file_param;
    localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0, we = 1'b0, ra_en = 1'b0, rb_en = 1'b0, clr_req = 1'b0;
    logic [4:0]  waddr = '0, ra_addr = '0, rb_addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] ra_data, rb_data;
    logic        busy;

    logic        s_rst = 1'b0, s_we = 1'b0, s_ra_en = 1'b0, s_rb_en = 1'b0, s_clr = 1'b0;
    logic [4:0]  s_waddr = '0, s_ra_addr = '0, s_rb_addr = '0;
    logic [31:0] s_wdata = '0;
    logic [31:0] s_ra_data, s_rb_data;
    logic        s_busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_ra, m_rb;
    logic        m_busy;
    int          m_left;

    always #5 clk = ~clk;

    reg_file_param #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_ra_en(ra_en), .i_ra_addr(ra_addr), .o_ra_data(ra_data),
        .i_rb_en(rb_en), .i_rb_addr(rb_addr), .o_rb_data(rb_data),
        .i_clr_req(clr_req), .o_busy(busy)
    );

    reg_file_param #(.WIDTH(32), .DEPTH(20), .AW(5), .ZERO_REG(1)) u_small (
        .i_clk(clk), .i_rst(s_rst), .i_we(s_we), .i_waddr(s_waddr), .i_wdata(s_wdata),
        .i_ra_en(s_ra_en), .i_ra_addr(s_ra_addr), .o_ra_data(s_ra_data),
        .i_rb_en(s_rb_en), .i_rb_addr(s_rb_addr), .o_rb_data(s_rb_data),
        .i_clr_req(s_clr), .o_busy(s_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit addr_ok(input logic [4:0] a);
        return (int'(a) < DEPTH) && (a != 5'd0);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit wr_acc,
                                               input logic [4:0] wa, input logic [31:0] wd);
        logic [31:0] v;
        v = 32'd0;
        if (addr_ok(a)) begin
            v = m_mem[a];
            if (BYP && wr_acc && (wa == a)) v = wd;
        end
        return v;
    endfunction

    // Behavioural view: a clear is "m_left entries still to zero, lowest index first".
    task automatic model_step(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic ae, input logic [4:0] aa, input logic be, input logic [4:0] ba,
                              input logic c);
        bit wr_acc;
        if (r) begin
            foreach (m_mem[i]) m_mem[i] = 32'd0;
            m_ra = 32'd0; m_rb = 32'd0; m_left = 0; m_busy = 1'b0;
        end else begin
            wr_acc = (m_left == 0) && !c && w && addr_ok(wa);
            if (ae) m_ra = model_read(aa, wr_acc, wa, wd);
            if (be) m_rb = model_read(ba, wr_acc, wa, wd);
            if (m_left > 0) begin
                m_mem[DEPTH - m_left] = 32'd0;
                m_left--;
            end else if (c) begin
                m_left = DEPTH;
            end else if (wr_acc) begin
                m_mem[wa] = wd;
            end
            m_busy = (m_left > 0);
        end
    endtask

    task automatic cycle(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ae, input logic [4:0] aa, input logic be, input logic [4:0] ba,
                         input logic c);
        rst = r; we = w; waddr = wa; wdata = wd;
        ra_en = ae; ra_addr = aa; rb_en = be; rb_addr = ba; clr_req = c;
        model_step(r, w, wa, wd, ae, aa, be, ba, c);
        @(posedge clk);
        #1;
        check("ra_data", ra_data, m_ra);
        check("rb_data", rb_data, m_rb);
        check("busy", {31'd0, busy}, {31'd0, m_busy});
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, a, d, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, a, 1'b1, b, 1'b0);
    endtask

    task automatic s_cycle(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                           input logic ae, input logic [4:0] aa, input logic be, input logic [4:0] ba,
                           input logic c);
        s_rst = r; s_we = w; s_waddr = wa; s_wdata = wd;
        s_ra_en = ae; s_ra_addr = aa; s_rb_en = be; s_rb_addr = ba; s_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          busy_cnt;
        logic        r, w, c, ae, be;
        logic [4:0]  wa, aa, ba;
        logic [31:0] wd;

        // Reset, then sweep every address on both ports.
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("rst_ra", ra_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < DEPTH; i++) rd(5'(i), 5'(DEPTH - 1 - i));

        // Write then read, then hold with enable low.
        wr(5'd3, 32'd10);
        rd(5'd3, 5'd3);
        check("wr_rd", ra_data, 32'd10);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0);
        check("hold", ra_data, 32'd10);

        // Same-edge write/read collision and zero register.
        wr(5'd7, 32'd20);
        cycle(1'b0, 1'b1, 5'd7, 32'd50, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
        check("collide", ra_data, BYP ? 32'd50 : 32'd20);
        rd(5'd7, 5'd7);
        check("after_collide", rb_data, 32'd50);
        wr(5'd0, 32'd99);
        rd(5'd0, 5'd0);
        check("zero_reg", ra_data, 32'd0);

        // Fill, bulk clear, dropped write at T+3, read of addr 31 at T+5.
        for (int i = 0; i < DEPTH; i++) wr(5'(i), 32'(100 + i));
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        busy_cnt = busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 3) wr(5'd2, 32'd77);
            else if (k == 5) rd(5'd31, 5'd30);
            else idle();
            if (k == 5) check("clr_rd31", ra_data, 32'd131);
            if (busy) busy_cnt++;
        end
        check("busy_len", 32'(busy_cnt), 32'd32);
        for (int i = 0; i < DEPTH; i++) rd(5'(i), 5'(i));
        rd(5'd2, 5'd31);
        check("clr_drop", ra_data, 32'd0);
        check("clr_last", rb_data, 32'd0);

        // Reset aborts a clear in progress.
        wr(5'd5, 32'd55);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        for (int k = 1; k < 10; k++) idle();
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("rst_abort", {31'd0, busy}, 32'd0);
        wr(5'd4, 32'h1234);
        rd(5'd4, 5'd5);
        check("post_rst_wr", ra_data, 32'h1234);
        check("post_rst_clr", rb_data, 32'd0);

        // Random traffic with occasional clears and resets.
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            c  = ($urandom_range(0, 59) == 0);
            w  = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            ae = 1'($urandom_range(0, 1));
            be = 1'($urandom_range(0, 1));
            aa = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ba = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            cycle(r, w, wa, wd, ae, aa, be, ba, c);
        end
        rst = 1'b0; we = 1'b0; ra_en = 1'b0; rb_en = 1'b0; clr_req = 1'b0;

        // DEPTH=20 instance: out-of-range write/read and a 20-cycle clear.
        s_cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        s_cycle(1'b0, 1'b1, 5'd25, 32'hDEAD, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        s_cycle(1'b0, 1'b1, 5'd19, 32'h19, 1'b1, 5'd25, 1'b1, 5'd5, 1'b0);
        check("s_rd25", s_ra_data, 32'd0);
        check("s_alias5", s_rb_data, 32'd0);
        s_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd19, 1'b1, 5'd25, 1'b0);
        check("s_rd19", s_ra_data, 32'h19);
        check("s_rb25", s_rb_data, 32'd0);
        for (int i = 1; i < 19; i++)
            s_cycle(1'b0, 1'b1, 5'(i), 32'(200 + i), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        s_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0, 5'd0, 1'b1);
        check("s_pre_clr", s_ra_data, 32'd210);
        busy_cnt = s_busy ? 1 : 0;
        for (int k = 1; k <= 30; k++) begin
            s_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
            if (s_busy) busy_cnt++;
        end
        check("s_busy_len", 32'(busy_cnt), 32'd20);
        s_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd19, 1'b1, 5'd10, 1'b0);
        check("s_clr19", s_ra_data, 32'd0);
        check("s_clr10", s_rb_data, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
